// File: rtl/blink_if.sv
// Request/status bundle between control logic and blink_driver.
interface blink_if #(
  parameter int CNT_W = 4
);
  logic             trig;
  logic [CNT_W-1:0] trig_cnt;
  logic             out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (output trig, trig_cnt, input out, busy, done, ovf);
  modport slave  (input trig, trig_cnt, output out, busy, done, ovf);
endinterface

// File: rtl/blink_driver.sv
// Turns single-cycle requests into timed on/off blink patterns on a level output.
// Optional one-deep request buffer enabled by defining BLINK_PENDING_EN.
module blink_driver #(
  parameter int ON_CYCLES  = 1000,
  parameter int OFF_CYCLES = 1000,
  parameter int CNT_W      = 4,
  parameter int TMR_W      = 10
) (
  input  logic   clk,
  input  logic   rst,
  blink_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_q, busy_q, done_q, ovf_q;
  logic             ovf_d, done_d;
  logic             req_s;
  logic             chain_vld_s;
  logic [CNT_W-1:0] chain_cnt_s;
`ifdef BLINK_PENDING_EN
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_q, pend_d;
`endif

  assign req_s = bus.trig && (bus.trig_cnt != {CNT_W{1'b0}});

  // Next-state, timer, count and request-buffer logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    chain_vld_s = 1'b0;
    chain_cnt_s = {CNT_W{1'b0}};
`ifdef BLINK_PENDING_EN
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    // Capture first, so a request in the final OFF cycle can chain immediately.
    if (req_s && (state_q != S_IDLE)) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = bus.trig_cnt;
      end
    end else begin
      pend_vld_d = pend_vld_d;
    end
    chain_vld_s = pend_vld_d;
    chain_cnt_s = pend_d;
`else
    if (req_s && (state_q != S_IDLE)) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          state_d = S_ON;
          timer_d = {TMR_W{1'b0}};
          rem_d   = bus.trig_cnt;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          state_d = S_OFF;
          timer_d = {TMR_W{1'b0}};
          rem_d   = rem_q - CNT_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = {TMR_W{1'b0}};
          if (rem_q != {CNT_W{1'b0}}) begin
            state_d = S_ON;
          end else if (chain_vld_s) begin
            state_d = S_ON;
            rem_d   = chain_cnt_s;
`ifdef BLINK_PENDING_EN
            pend_vld_d = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = {TMR_W{1'b0}};
        rem_d   = {CNT_W{1'b0}};
      end
    endcase
    // done is registered, so it is raised on entry to the final OFF cycle.
    done_d = (state_d == S_OFF) && (timer_d == OFF_LAST) && (rem_d == {CNT_W{1'b0}});
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= {TMR_W{1'b0}};
      rem_q   <= {CNT_W{1'b0}};
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef BLINK_PENDING_EN
      pend_vld_q <= 1'b0;
      pend_q     <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      out_q   <= (state_d == S_ON);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef BLINK_PENDING_EN
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
`endif
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_blink_driver.sv
// Directed bench for blink_driver with ON_CYCLES=3, OFF_CYCLES=2; covers both BLINK_PENDING_EN builds.
module tb_blink_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  blink_if #(.CNT_W(4)) bus ();

  blink_driver #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .CNT_W     (4),
    .TMR_W     (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    bus.trig     = 1'b0;
    bus.trig_cnt = 4'd0;
  endtask

  task automatic check(input string tag, input logic eo, input logic eb,
                       input logic ed, input logic ev);
    checks += 4;
    assert (bus.out === eo) else begin
      failures++;
      $error("FAIL %s out: got %b expected %b", tag, bus.out, eo);
    end
    assert (bus.busy === eb) else begin
      failures++;
      $error("FAIL %s busy: got %b expected %b", tag, bus.busy, eb);
    end
    assert (bus.done === ed) else begin
      failures++;
      $error("FAIL %s done: got %b expected %b", tag, bus.done, ed);
    end
    assert (bus.ovf === ev) else begin
      failures++;
      $error("FAIL %s ovf: got %b expected %b", tag, bus.ovf, ev);
    end
  endtask

  // Drive inputs for this cycle, advance one clock, check the next cycle.
  task automatic cyc(input string tag, input logic t, input logic [3:0] c,
                     input logic eo, input logic eb, input logic ed, input logic ev);
    bus.trig     = t;
    bus.trig_cnt = c;
    step();
    check(tag, eo, eb, ed, ev);
  endtask

  // Expected n-blink pattern following a request driven in the current cycle.
  task automatic run_blinks(input string tag, input int n, input logic ev);
    for (int b = 0; b < n; b++) begin
      for (int j = 0; j < 3; j++) begin
        step();
        check(tag, 1'b1, 1'b1, 1'b0, ev);
        busy_cnt += bus.busy ? 1 : 0;
        done_cnt += bus.done ? 1 : 0;
      end
      for (int j = 0; j < 2; j++) begin
        step();
        check(tag, 1'b0, 1'b1, (b == n - 1) && (j == 1), ev);
        busy_cnt += bus.busy ? 1 : 0;
        done_cnt += bus.done ? 1 : 0;
      end
    end
  endtask

  task automatic do_rst(input string tag);
    rst = 1'b1;
    step();
    check(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bus.trig     = 1'b0;
    bus.trig_cnt = 4'd0;

    // Reset state
    step();
    step();
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("idle0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("idle1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two blinks, then quiet
    bus.trig = 1'b1; bus.trig_cnt = 4'd2;
    run_blinks("cnt2", 2, 1'b0);
    cyc("cnt2_after0", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("cnt2_after1", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Zero-count request is a no-op
    bus.trig = 1'b1; bus.trig_cnt = 4'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("cnt0", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a pattern, then a fresh single blink
    cyc("mid_on0", 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mid_on1", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mid_on2", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("mid_off0", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mid_off1", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_rst("mid_rst");
    for (int i = 0; i < 4; i++) begin
      cyc("post_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.trig = 1'b1; bus.trig_cnt = 4'd1;
    run_blinks("after_rst", 1, 1'b0);
    cyc("after_rst_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Request arriving in the final OFF cycle
    cyc("term_on0", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("term_on1", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("term_on2", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("term_off0", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("term_off1", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef BLINK_PENDING_EN
    bus.trig = 1'b1; bus.trig_cnt = 4'd2;
    run_blinks("term_chain", 2, 1'b0);
    cyc("term_chain_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    cyc("term_drop", 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("term_drop_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_rst("term_rst");
`endif

    // Requests while busy
`ifdef BLINK_PENDING_EN
    cyc("pend_c11", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("pend_c12", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("pend_c13", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("pend_c14", 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("pend_c15", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("pend_c16", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("pend_c17", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("pend_c18", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("pend_c19", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("pend_c20", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("pend_c21", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("pend_sticky", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    cyc("drop_c11", 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("drop_c12", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("drop_c13", 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("drop_c14", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("drop_c15", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc("drop_c16", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("drop_sticky", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    do_rst("ovf_clear");

    // Maximum count
    busy_cnt = 0;
    done_cnt = 0;
    bus.trig = 1'b1; bus.trig_cnt = 4'd15;
    run_blinks("cnt15", 15, 1'b0);
    cyc("cnt15_idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    assert (busy_cnt == 75) else begin
      failures++;
      $error("FAIL cnt15_busy_cycles: got %0d expected %0d", busy_cnt, 75);
    end
    assert (done_cnt == 1) else begin
      failures++;
      $error("FAIL cnt15_done_pulses: got %0d expected %0d", done_cnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
